// File: rtl/cla_seq_pkg.sv
// Shared types and elaboration helpers for the sequential CLA adder.
// No logic of its own; sizes the chunk counter and names the FSM states.
// Imported by cla_seq_adder.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Number of CHUNK-wide slices needed to cover WIDTH bits.
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the chunk index counter; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational CHUNK-bit carry-lookahead adder slice.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller registers the outputs.
//
// Ports:
//   a, b   CHUNK-bit operands
//   ci     carry into bit 0
//   s      CHUNK-bit sum
//   co     carry out of the MSB
//   c_msb  carry into the MSB (only with CLA_SEQ_OVF_EN, used for signed overflow)
module cla_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             c_msb
`endif
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             acc;
    logic             pp;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded to the flat sum-of-products form
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, so no carry waits on another.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b1;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (ci & pp);
        end
    end

    assign s  = p ^ c[CHUNK-1:0];
    assign co = c[CHUNK];
`ifdef CLA_SEQ_OVF_EN
    assign c_msb = c[CHUNK-1];
`endif

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder/subtractor: one CLA slice reused over WIDTH/CHUNK cycles.
// Latency: out_valid rises NCHUNK cycles after the accept edge.
// Backpressure: result held in HOLD while out_ready=0; in_ready low in CALC and stalled HOLD.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b, ci, sub)
//   sub                  1: a-b (b inverted, carry-in forced to 1, ci ignored)
//   out_valid/out_ready  result handshake (s, co, ovf)
//   s, co                registered sum and carry out (co=1 means no borrow for sub)
//   ovf                  signed overflow, only when CLA_SEQ_OVF_EN is defined
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);
    localparam int SW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [SW-1:0]    sh;
    logic [CHUNK-1:0] sl_s;
    logic             sl_co;
    logic             accept;
`ifdef CLA_SEQ_OVF_EN
    logic             sl_cmsb;
`endif

    // Bit offset of the chunk being worked on.
    assign sh = SW'(32'(idx_q) * CHUNK);

    // Gated by rst_n so the block refuses operands while held in reset.
    assign in_ready = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
    assign accept   = in_valid & in_ready;

    cla_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_q[sh +: CHUNK]),
        .b    (b_q[sh +: CHUNK]),
        .ci   (carry_q),
        .s    (sl_s),
        .co   (sl_co)
`ifdef CLA_SEQ_OVF_EN
        ,
        .c_msb(sl_cmsb)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            s         <= '0;
            co        <= 1'b0;
            out_valid <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (accept) begin
            // Taken from IDLE or from HOLD in the same cycle the result is consumed.
            a_q       <= a;
            b_q       <= b ^ {WIDTH{sub}};
            carry_q   <= sub | ci;
            idx_q     <= '0;
            out_valid <= 1'b0;
            state     <= CALC;
        end else begin
            case (state)
                CALC: begin
                    s[sh +: CHUNK] <= sl_s;
                    carry_q        <= sl_co;
                    idx_q          <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        co        <= sl_co;
`ifdef CLA_SEQ_OVF_EN
                        ovf       <= sl_cmsb ^ sl_co;
`endif
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
